// File: rtl/edge_pixel_scanner.sv
// edge_pixel_scanner: raster-scans the binary edge image and streams the (x, y)
// of every set pixel over valid/ready, absorbing 1-cycle RAM latency with a skid.
`default_nettype none

module edge_pixel_scanner #(
    parameter int X_MAX   = 1000,
    parameter int Y_MAX   = 1000,
    parameter int MSB_XY  = 11,
    parameter int MSB_CNT = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    output logic               rd_en_o,
    output logic [MSB_XY:0]    rd_x_o,
    output logic [MSB_XY:0]    rd_y_o,
    input  logic               rd_data_i,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic [MSB_XY:0]    x_out_o,
    output logic [MSB_XY:0]    y_out_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [MSB_CNT:0]   edge_count_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [MSB_XY:0]  X_LAST   = (MSB_XY+1)'(X_MAX);
    localparam logic [MSB_XY:0]  Y_LAST   = (MSB_XY+1)'(Y_MAX);
    localparam logic [MSB_XY:0]  XY_ONE   = (MSB_XY+1)'(1);
    localparam logic [MSB_CNT:0] CNT_ONE  = (MSB_CNT+1)'(1);
    localparam logic [MSB_CNT:0] CNT_FULL = '1;

    logic [1:0]        state_q, state_d;
    logic [MSB_XY:0]   scan_x_q, scan_x_d;
    logic [MSB_XY:0]   scan_y_q, scan_y_d;
    logic              pipe_v_q;
    logic [MSB_XY:0]   pipe_x_q, pipe_y_q;
    logic              out_v_q, out_v_d;
    logic [MSB_XY:0]   out_x_q, out_x_d;
    logic [MSB_XY:0]   out_y_q, out_y_d;
    logic              skid_v_q, skid_v_d;
    logic [MSB_XY:0]   skid_x_q, skid_x_d;
    logic [MSB_XY:0]   skid_y_q, skid_y_d;
    logic [MSB_CNT:0]  cnt_q, cnt_d;

    logic w_consume;
    logic w_out_free;
    logic w_stall;
    logic w_rd_en;
    logic w_ret;
    logic w_drained;

    assign w_consume  = out_v_q & pix_ready_i;
    assign w_out_free = ~out_v_q | w_consume;
    assign w_stall    = out_v_q & ~pix_ready_i;
    // A read is only issued when its return is guaranteed a free slot.
    assign w_rd_en    = (state_q == S_SCAN) & ~skid_v_q & ~w_stall;
    assign w_ret      = pipe_v_q & rd_data_i;
    assign w_drained  = ~pipe_v_q & ~skid_v_q & w_out_free;

    always_comb begin
        state_d  = state_q;
        scan_x_d = scan_x_q;
        scan_y_d = scan_y_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_SCAN;
                    scan_x_d = '0;
                    scan_y_d = '0;
                end
            end
            S_SCAN: begin
                if (w_rd_en) begin
                    if (scan_x_q == X_LAST) begin
                        scan_x_d = '0;
                        if (scan_y_q == Y_LAST) begin
                            scan_y_d = '0;
                            state_d  = S_DRAIN;
                        end else begin
                            scan_y_d = scan_y_q + XY_ONE;
                        end
                    end else begin
                        scan_x_d = scan_x_q + XY_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register is refilled from the skid first so raster order holds.
    always_comb begin
        out_v_d  = out_v_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        skid_v_d = skid_v_q;
        skid_x_d = skid_x_q;
        skid_y_d = skid_y_q;
        if (w_out_free) begin
            if (skid_v_q) begin
                out_v_d  = 1'b1;
                out_x_d  = skid_x_q;
                out_y_d  = skid_y_q;
                skid_v_d = w_ret;
                if (w_ret) begin
                    skid_x_d = pipe_x_q;
                    skid_y_d = pipe_y_q;
                end
            end else if (w_ret) begin
                out_v_d = 1'b1;
                out_x_d = pipe_x_q;
                out_y_d = pipe_y_q;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (w_ret) begin
            skid_v_d = 1'b1;
            skid_x_d = pipe_x_q;
            skid_y_d = pipe_y_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_consume && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if ((state_q == S_IDLE) && start_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            scan_x_q <= '0;
            scan_y_q <= '0;
            pipe_v_q <= 1'b0;
            pipe_x_q <= '0;
            pipe_y_q <= '0;
            out_v_q  <= 1'b0;
            out_x_q  <= '0;
            out_y_q  <= '0;
            skid_v_q <= 1'b0;
            skid_x_q <= '0;
            skid_y_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            scan_x_q <= scan_x_d;
            scan_y_q <= scan_y_d;
            pipe_v_q <= w_rd_en;
            if (w_rd_en) begin
                pipe_x_q <= scan_x_q;
                pipe_y_q <= scan_y_q;
            end
            out_v_q  <= out_v_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            skid_v_q <= skid_v_d;
            skid_x_q <= skid_x_d;
            skid_y_q <= skid_y_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_en_o      = w_rd_en;
    assign rd_x_o       = scan_x_q;
    assign rd_y_o       = scan_y_q;
    assign pix_valid_o  = out_v_q;
    assign x_out_o      = out_x_q;
    assign y_out_o      = out_y_q;
    assign busy_o       = (state_q == S_SCAN) | (state_q == S_DRAIN);
    assign done_o       = (state_q == S_DRAIN) & w_drained;
    assign edge_count_o = cnt_q;

endmodule

`default_nettype wire

// File: doc/edge_pixel_scanner.md
Name: edge_pixel_scanner

Overview:
- Raster-scans the binary edge image memory and streams the (x, y) coordinate of every set pixel to the Hough voting datapath over a valid/ready handshake.
- It is the reader side of the image store: the line-drawing post stage writes image[yi][xi].
- Handles 1-cycle synchronous RAM read latency and output back-pressure without losing or duplicating pixels.

Parameters:
- X_MAX, 1000, last column index; columns 0..X_MAX.
- Y_MAX, 1000, last row index; rows 0..Y_MAX.
- MSB_XY, 11, MSB of coordinate buses (12-bit, unsigned in this block).
- MSB_CNT, 19, MSB of edge_count.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a full-frame scan.
- rd_en  out  1  image memory read strobe.
- rd_x  out  MSB_XY+1  column address of the read.
- rd_y  out  MSB_XY+1  row address of the read.
- rd_data  in  1  pixel value; valid exactly 1 cycle after rd_en.
- pix_valid  out  1  x_out/y_out hold an edge pixel.
- pix_ready  in  1  consumer accepts the pixel when pix_valid & pix_ready.
- x_out  out  MSB_XY+1  edge pixel column.
- y_out  out  MSB_XY+1  edge pixel row.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse when the frame is fully emitted.
- edge_count  out  MSB_CNT+1  number of handshaken pixels in the current or last frame.

Behaviour:
- Reset:
  - state=IDLE; rd_en=0; rd_x=rd_y=0; pix_valid=0; x_out=y_out=0.
  - skid buffer empty; busy=0; done=0; edge_count=0.
  - Reset mid-scan aborts immediately. The in-flight rd_data is discarded.
- States:
  - IDLE: start=1 -> SCAN, clear edge_count and scan counters.
  - SCAN: issue reads in raster order, x fastest: (0,0),(1,0)..(X_MAX,0),(0,1)..(X_MAX,Y_MAX). After the (X_MAX,Y_MAX) read is issued -> DRAIN.
  - DRAIN: wait until no read is in flight, the skid is empty, and pix_valid=0 (or is being accepted this cycle). Then pulse done for 1 cycle and go to IDLE.
  - start outside IDLE is ignored.
- Read issue: rd_en = (state==SCAN) & ~skid_full & ~(pix_valid & ~pix_ready). The address counter advances only on cycles with rd_en=1. x wraps from X_MAX to 0 with y+1.
- Return path: one cycle after rd_en, if rd_data=1, the coordinate of that read (kept in a 1-deep address pipe) is loaded:
  - into the output register if it is empty or being consumed this cycle;
  - otherwise into the 1-entry skid buffer.
  - rd_data=0 produces nothing.
- Skid drain: when the output is consumed and the skid is full, the skid moves into the output register the same edge. A simultaneous return then goes into the skid; ordering is preserved. Raster order is never violated.
- pix_valid/x_out/y_out are registered and remain stable while pix_valid & ~pix_ready.
- edge_count increments on each pix_valid & pix_ready. It saturates at all-ones and holds its value in IDLE until the next start.
- Latency: start sampled at edge T -> rd_en for (0,0) in cycle T+1 -> rd_data at T+2 -> pix_valid from T+3 if pixel (0,0) is set.
- Throughput: 1 pixel read per cycle while pix_ready=1. A frame with pix_ready held at 1 takes (X_MAX+1)(Y_MAX+1) read cycles plus 2 cycles of drain before done.
- busy=1 from T+1 through the cycle of the done pulse. done and busy drop together on the following edge.

Test Plan:
- Reset mid-SCAN with pix_valid=1 and skid full -> next cycle pix_valid=0, rd_en=0, busy=0, edge_count=0. A later start rescans from (0,0).
- X_MAX=3, Y_MAX=2, all-zero image, pix_ready=1, start at T -> rd_en high T+1..T+12 with addresses (0,0)..(3,2); pix_valid never high; done at T+14; edge_count=0.
- Same geometry, pixels (0,0),(3,0),(2,2) set, pix_ready=1 -> emits (0,0) at T+3, (3,0) at T+6, (2,2) at T+13; done at T+14; edge_count=3.
- All pixels set, pix_ready low for 4 cycles starting T+4 -> rd_en stalls and no pixel is lost or duplicated. All 12 coordinates arrive in raster order; edge_count=12.
- start pulsed during SCAN and during DRAIN -> ignored; exactly one done pulse; the counter does not restart.
- Default parameters, single pixel (1000,1000) set -> x_out=1000, y_out=1000 is the last output; done follows it; edge_count=1.
